// File: rtl/mips_pkg.sv
// Shared MIPS encoding definitions: op_t, opcode/funct constants and field positions.
// Used by instr_encoder and the CPU decoder so both agree bit-for-bit.
package mips_pkg;

    // I-type ops (OP_ADDI..OP_BGEZ) are kept contiguous so range checks stay simple.
    typedef enum logic [4:0] {
        OP_RTYPE = 5'd0,
        OP_SLL   = 5'd1,
        OP_SRL   = 5'd2,
        OP_SRA   = 5'd3,
        OP_JR    = 5'd4,
        OP_ADDI  = 5'd5,
        OP_ADDIU = 5'd6,
        OP_ANDI  = 5'd7,
        OP_ORI   = 5'd8,
        OP_XORI  = 5'd9,
        OP_SLTI  = 5'd10,
        OP_LUI   = 5'd11,
        OP_LW    = 5'd12,
        OP_SW    = 5'd13,
        OP_LB    = 5'd14,
        OP_SB    = 5'd15,
        OP_BEQ   = 5'd16,
        OP_BNE   = 5'd17,
        OP_BLEZ  = 5'd18,
        OP_BGTZ  = 5'd19,
        OP_BGEZ  = 5'd20,
        OP_J     = 5'd21,
        OP_JAL   = 5'd22
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_ERROR = 2'd2
    } enc_state_t;

    localparam logic [5:0] OPC_SPECIAL = 6'b000000;
    localparam logic [5:0] OPC_REGIMM  = 6'b000001;
    localparam logic [5:0] OPC_J       = 6'b000010;
    localparam logic [5:0] OPC_JAL     = 6'b000011;
    localparam logic [5:0] OPC_BEQ     = 6'b000100;
    localparam logic [5:0] OPC_BNE     = 6'b000101;
    localparam logic [5:0] OPC_BLEZ    = 6'b000110;
    localparam logic [5:0] OPC_BGTZ    = 6'b000111;
    localparam logic [5:0] OPC_ADDI    = 6'b001000;
    localparam logic [5:0] OPC_ADDIU   = 6'b001001;
    localparam logic [5:0] OPC_SLTI    = 6'b001010;
    localparam logic [5:0] OPC_ANDI    = 6'b001100;
    localparam logic [5:0] OPC_ORI     = 6'b001101;
    localparam logic [5:0] OPC_XORI    = 6'b001110;
    localparam logic [5:0] OPC_LUI     = 6'b001111;
    localparam logic [5:0] OPC_LB      = 6'b100000;
    localparam logic [5:0] OPC_LW      = 6'b100011;
    localparam logic [5:0] OPC_SB      = 6'b101000;
    localparam logic [5:0] OPC_SW      = 6'b101011;

    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [4:0] RT_BGEZ = 5'b00001;

    localparam int OPCODE_HI = 31, OPCODE_LO = 26;
    localparam int RS_HI     = 25, RS_LO     = 21;
    localparam int RT_HI     = 20, RT_LO     = 16;
    localparam int RD_HI     = 15, RD_LO     = 11;
    localparam int SHAMT_HI  = 10, SHAMT_LO  = 6;
    localparam int FUNCT_HI  = 5,  FUNCT_LO  = 0;
    localparam int IMM_HI    = 15, IMM_LO    = 0;
    localparam int TARGET_HI = 25, TARGET_LO = 0;

    function automatic logic [31:0] pack_r(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] shamt,
                                           input logic [5:0] funct);
        logic [31:0] w;
        w = '0;
        w[OPCODE_HI:OPCODE_LO] = OPC_SPECIAL;
        w[RS_HI:RS_LO]         = rs;
        w[RT_HI:RT_LO]         = rt;
        w[RD_HI:RD_LO]         = rd;
        w[SHAMT_HI:SHAMT_LO]   = shamt;
        w[FUNCT_HI:FUNCT_LO]   = funct;
        return w;
    endfunction

    function automatic logic [31:0] pack_i(input logic [5:0] opc, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        logic [31:0] w;
        w = '0;
        w[OPCODE_HI:OPCODE_LO] = opc;
        w[RS_HI:RS_LO]         = rs;
        w[RT_HI:RT_LO]         = rt;
        w[IMM_HI:IMM_LO]       = imm;
        return w;
    endfunction

    function automatic logic [31:0] pack_j(input logic [5:0] opc, input logic [25:0] target);
        logic [31:0] w;
        w = '0;
        w[OPCODE_HI:OPCODE_LO] = opc;
        w[TARGET_HI:TARGET_LO] = target;
        return w;
    endfunction

endpackage

// File: rtl/instr_encode_comb.sv
// Combinational op/field -> 32-bit MIPS word mapper with an illegal-request flag.
// INSTR_ENCODER_IMM_CHECK_EN: flag 16-bit-immediate ops whose req_imm[25:16] is non-zero.
module instr_encode_comb
    import mips_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  func,
    input  logic [25:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

`ifdef INSTR_ENCODER_IMM_CHECK_EN
    localparam bit IMM_CHECK = 1'b1;
`else
    localparam bit IMM_CHECK = 1'b0;
`endif

    op_t  op_e;
    logic imm16_op;

    assign op_e     = op_t'(op);
    assign imm16_op = (op >= OP_ADDI) && (op <= OP_BGEZ);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (op_e)
            OP_RTYPE: word = pack_r(rs, rt, rd, shamt, func);
            OP_SLL:   word = pack_r(rs, rt, rd, shamt, FN_SLL);
            OP_SRL:   word = pack_r(rs, rt, rd, shamt, FN_SRL);
            OP_SRA:   word = pack_r(rs, rt, rd, shamt, FN_SRA);
            OP_JR:    word = pack_r(rs, 5'd0, 5'd0, 5'd0, FN_JR);
            OP_ADDI:  word = pack_i(OPC_ADDI,  rs, rt, imm[15:0]);
            OP_ADDIU: word = pack_i(OPC_ADDIU, rs, rt, imm[15:0]);
            OP_ANDI:  word = pack_i(OPC_ANDI,  rs, rt, imm[15:0]);
            OP_ORI:   word = pack_i(OPC_ORI,   rs, rt, imm[15:0]);
            OP_XORI:  word = pack_i(OPC_XORI,  rs, rt, imm[15:0]);
            OP_SLTI:  word = pack_i(OPC_SLTI,  rs, rt, imm[15:0]);
            OP_LUI:   word = pack_i(OPC_LUI,   5'd0, rt, imm[15:0]);
            OP_LW:    word = pack_i(OPC_LW,    rs, rt, imm[15:0]);
            OP_SW:    word = pack_i(OPC_SW,    rs, rt, imm[15:0]);
            OP_LB:    word = pack_i(OPC_LB,    rs, rt, imm[15:0]);
            OP_SB:    word = pack_i(OPC_SB,    rs, rt, imm[15:0]);
            OP_BEQ:   word = pack_i(OPC_BEQ,   rs, rt, imm[15:0]);
            OP_BNE:   word = pack_i(OPC_BNE,   rs, rt, imm[15:0]);
            OP_BLEZ:  word = pack_i(OPC_BLEZ,  rs, rt, imm[15:0]);
            OP_BGTZ:  word = pack_i(OPC_BGTZ,  rs, rt, imm[15:0]);
            OP_BGEZ:  word = pack_i(OPC_REGIMM, rs, RT_BGEZ, imm[15:0]);
            OP_J:     word = pack_j(OPC_J,   imm);
            OP_JAL:   word = pack_j(OPC_JAL, imm);
            default:  illegal = 1'b1;
        endcase
        if (IMM_CHECK && imm16_op && (imm[25:16] != '0)) begin
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts encode requests and writes MIPS words to instruction memory.
// Optional INSTR_ENCODER_IMM_CHECK_EN rejects I-type requests with non-zero req_imm[25:16].
module instr_encoder
    import mips_pkg::*;
#(
    parameter int                ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4:0]        req_op,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_shamt,
    input  logic [5:0]        req_func,
    input  logic [25:0]       req_imm,
    input  logic              load_addr,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              clear_err,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              err,
    output logic [1:0]        state_dbg
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE with no load_addr, and the request fields are
    // sampled on that edge. req_valid may be held; it is never dropped by the block.

    enc_state_t        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic [31:0]       enc_word;
    logic              enc_illegal;
    logic              fire;

    instr_encode_comb u_comb (
        .op      (req_op),
        .rs      (req_rs),
        .rt      (req_rt),
        .rd      (req_rd),
        .shamt   (req_shamt),
        .func    (req_func),
        .imm     (req_imm),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    assign fire = req_valid && req_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (fire) state_d = enc_illegal ? ST_ERROR : ST_WRITE;
            ST_WRITE: state_d = ST_IDLE;
            ST_ERROR: if (clear_err) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // load_addr wins over a pending request by dropping req_ready for that cycle.
    always_comb begin
        req_ready = (state_q == ST_IDLE) && !load_addr;
        wr_en     = (state_q == ST_WRITE);
        err       = (state_q == ST_ERROR);
        state_dbg = state_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q   <= RESET_ADDR;
            wr_data <= '0;
        end else begin
            if (state_q == ST_IDLE && load_addr) begin
                ptr_q <= start_addr;
            end else if (state_q == ST_WRITE) begin
                ptr_q <= ptr_q + ADDR_W'(4);
            end
            if (fire && !enc_illegal) begin
                wr_data <= enc_word;
            end
        end
    end

    assign wr_addr = ptr_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed literal cases plus randomized traffic against a
// transaction-level reference model with an expected-write queue.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_op = '0, req_rs = '0, req_rt = '0, req_rd = '0, req_shamt = '0;
    logic [5:0]  req_func = '0;
    logic [25:0] req_imm = '0;
    logic        load_addr = 1'b0;
    logic [15:0] start_addr = '0;
    logic        clear_err = 1'b0;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic        err;
    logic [1:0]  state_dbg;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(16), .RESET_ADDR(16'h0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_rs     (req_rs),
        .req_rt     (req_rt),
        .req_rd     (req_rd),
        .req_shamt  (req_shamt),
        .req_func   (req_func),
        .req_imm    (req_imm),
        .load_addr  (load_addr),
        .start_addr (start_addr),
        .clear_err  (clear_err),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .err        (err),
        .state_dbg  (state_dbg)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
`ifdef INSTR_ENCODER_IMM_CHECK_EN
    localparam bit IMM_CHECK = 1'b1;
`else
    localparam bit IMM_CHECK = 1'b0;
`endif

    // I-type opcodes for op values 5..19, in op order.
    int unsigned itype_opc [15] = '{8, 9, 12, 13, 14, 10, 15, 35, 43, 32, 40, 4, 5, 6, 7};

    function automatic logic [32:0] ref_encode(input int op, input int unsigned rs,
                                               input int unsigned rt, input int unsigned rd,
                                               input int unsigned sh, input int unsigned fn,
                                               input logic [25:0] imm);
        logic [31:0]  w;
        bit           ill;
        bit           itype;
        int unsigned  i16;
        w = '0; ill = 0; itype = 0;
        i16 = int'(imm[15:0]);
        if (op == 0) w = (rs << 21) | (rt << 16) | (rd << 11) | (sh << 6) | fn;
        else if (op == 1) w = (rs << 21) | (rt << 16) | (rd << 11) | (sh << 6);
        else if (op == 2) w = (rs << 21) | (rt << 16) | (rd << 11) | (sh << 6) | 2;
        else if (op == 3) w = (rs << 21) | (rt << 16) | (rd << 11) | (sh << 6) | 3;
        else if (op == 4) w = (rs << 21) | 8;
        else if (op >= 5 && op <= 19) begin
            itype = 1;
            w = (itype_opc[op-5] << 26) | ((op == 11 ? 0 : rs) << 21) | (rt << 16) | i16;
        end else if (op == 20) begin
            itype = 1;
            w = (1 << 26) | (rs << 21) | (1 << 16) | i16;
        end else if (op == 21) w = (2 << 26) | int'(imm);
        else if (op == 22) w = (3 << 26) | int'(imm);
        else ill = 1;
        if (IMM_CHECK && itype && imm[25:16] != 0) ill = 1;
        return {ill, w};
    endfunction

    logic [31:0] exp_q[$];
    logic [15:0] exp_addr_q[$];
    int          m_phase = 0;   // 0 idle, 1 write pending, 2 error
    logic [15:0] m_ptr = 16'h0000;

    always @(posedge clk or posedge reset) begin
        logic [32:0] r;
        if (reset) begin
            m_phase = 0;
            m_ptr   = 16'h0000;
            exp_q.delete();
            exp_addr_q.delete();
        end else begin
            case (m_phase)
                0: if (load_addr) m_ptr = start_addr;
                   else if (req_valid) begin
                       r = ref_encode(int'(req_op), req_rs, req_rt, req_rd, req_shamt,
                                      req_func, req_imm);
                       if (r[32]) m_phase = 2;
                       else begin
                           exp_q.push_back(r[31:0]);
                           exp_addr_q.push_back(m_ptr);
                           m_phase = 1;
                       end
                   end
                1: begin m_ptr = m_ptr + 16'd4; m_phase = 0; end
                default: if (clear_err) m_phase = 0;
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    bit checking = 0;
    always @(negedge clk) begin
        if (checking) begin
            check("wr_en", {31'd0, wr_en}, {31'd0, m_phase == 1});
            check("req_ready", {31'd0, req_ready}, {31'd0, m_phase == 0 && !load_addr});
            check("err", {31'd0, err}, {31'd0, m_phase == 2});
            check("wr_addr", {16'd0, wr_addr}, {16'd0, m_ptr});
            if (wr_en) begin
                if (exp_q.size() == 0) check("spurious_write", {31'd0, wr_en}, 32'd0);
                else begin
                    check("wr_data", wr_data, exp_q.pop_front());
                    check("write_addr", {16'd0, wr_addr}, {16'd0, exp_addr_q.pop_front()});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input int op, input int rs, input int rt, input int rd,
                           input int sh, input int fn, input logic [25:0] imm);
        req_op = 5'(op); req_rs = 5'(rs); req_rt = 5'(rt); req_rd = 5'(rd);
        req_shamt = 5'(sh); req_func = 6'(fn); req_imm = imm;
        req_valid = 1'b1;
    endtask

    task automatic wait_accept();
        bit got = 0;
        for (int i = 0; i < 16 && !got; i++) begin
            @(negedge clk);
            got = req_ready;
            @(posedge clk);
            #1;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL accept_timeout: got no handshake expected one within 16 cycles");
        end
        req_valid = 1'b0;
    endtask

    task automatic expect_write(input string name, input logic [15:0] addr,
                                input logic [31:0] data);
        @(negedge clk);
        check({name, "_en"}, {31'd0, wr_en}, 32'd1);
        check({name, "_addr"}, {16'd0, wr_addr}, {16'd0, addr});
        check({name, "_data"}, wr_data, data);
    endtask

    task automatic load_ptr(input logic [15:0] a);
        load_addr = 1'b1; start_addr = a;
        @(posedge clk); #1;
        load_addr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 reset = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        checking = 1;

        @(negedge clk);
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        check("rst_wr_addr", {16'd0, wr_addr}, 32'h0000);
        check("rst_err", {31'd0, err}, 32'd0);
        @(posedge clk); #1;

        // ADDI rs=1 rt=2 imm=5
        set_req(5, 1, 2, 0, 0, 0, 26'h0005);
        wait_accept();
        expect_write("addi", 16'h0000, 32'h20220005);

        // SLL then J back-to-back from pointer 0
        @(posedge clk); #1;
        load_ptr(16'h0000);
        set_req(1, 0, 2, 3, 4, 0, 26'h0);
        wait_accept();
        set_req(21, 0, 0, 0, 0, 0, 26'h100);
        @(negedge clk);
        check("sll_en", {31'd0, wr_en}, 32'd1);
        check("sll_addr", {16'd0, wr_addr}, 32'h0000);
        check("sll_data", wr_data, 32'h00021900);
        check("b2b_ready_low", {31'd0, req_ready}, 32'd0);
        wait_accept();
        expect_write("j", 16'h0004, 32'h08000100);

        @(posedge clk); #1;
        set_req(20, 4, 7, 0, 0, 0, 26'hFFFE);
        wait_accept();
        expect_write("bgez", 16'h0008, 32'h0481FFFE);
        @(posedge clk); #1;
        set_req(4, 31, 5, 6, 7, 0, 26'h0);
        wait_accept();
        expect_write("jr", 16'h000C, 32'h03E00008);

        // pointer wrap
        @(posedge clk); #1;
        load_ptr(16'hFFFC);
        set_req(5, 1, 2, 0, 0, 0, 26'h0005);
        wait_accept();
        expect_write("wrap0", 16'hFFFC, 32'h20220005);
        @(posedge clk); #1;
        set_req(8, 3, 4, 0, 0, 0, 26'h1234);
        wait_accept();
        expect_write("wrap1", 16'h0000, 32'h34641234);

        // undefined op -> ERROR until clear_err
        @(posedge clk); #1;
        set_req(27, 1, 1, 1, 1, 1, 26'h1);
        wait_accept();
        set_req(5, 1, 2, 0, 0, 0, 26'h0005);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("illegal_err", {31'd0, err}, 32'd1);
            check("illegal_no_wr", {31'd0, wr_en}, 32'd0);
            check("illegal_ready", {31'd0, req_ready}, 32'd0);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        clear_err = 1'b1;
        @(posedge clk); #1;
        clear_err = 1'b0;
        @(negedge clk);
        check("cleared_err", {31'd0, err}, 32'd0);
        check("cleared_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;

        // reset while in WRITE
        set_req(6, 9, 10, 0, 0, 0, 26'h00AA);
        wait_accept();
        #1 reset = 1'b1;
        #1;
        check("rst_in_write_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_in_write_addr", {16'd0, wr_addr}, 32'h0000);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // upper immediate bits on an I-type op
        set_req(5, 1, 2, 0, 0, 0, 26'h10005);
        wait_accept();
`ifdef INSTR_ENCODER_IMM_CHECK_EN
        @(negedge clk);
        check("imm_check_err", {31'd0, err}, 32'd1);
        check("imm_check_no_wr", {31'd0, wr_en}, 32'd0);
        @(posedge clk); #1;
        clear_err = 1'b1;
        @(posedge clk); #1;
        clear_err = 1'b0;
`else
        expect_write("imm_drop", 16'h0000, 32'h20220005);
        @(posedge clk); #1;
`endif

        // randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            req_valid  = 1'($urandom_range(0, 1));
            req_op     = 5'($urandom_range(0, 25));
            req_rs     = 5'($urandom);
            req_rt     = 5'($urandom);
            req_rd     = 5'($urandom);
            req_shamt  = 5'($urandom);
            req_func   = 6'($urandom);
            req_imm    = ($urandom_range(0, 1) == 1) ? 26'($urandom) : {10'd0, 16'($urandom)};
            load_addr  = ($urandom_range(0, 7) == 0);
            start_addr = ($urandom_range(0, 3) == 0) ? 16'hFFFC : 16'($urandom);
            clear_err  = ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
        end
        req_valid = 1'b0; load_addr = 1'b0; clear_err = 1'b1;
        repeat (4) @(posedge clk);
        #1 clear_err = 1'b0;
        @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        checking = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, the write-address width in bits (byte address).
REQ-002 The block SHALL have parameter RESET_ADDR, default 0, the write-pointer value after reset.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port req_valid, input, 1 bit: an encode request is present.
REQ-006 The block SHALL have port req_ready, output, 1 bit: the block accepts a request this cycle.
REQ-007 The block SHALL have port req_op, input, 5 bits: operation, an op_t enum value.
REQ-008 The block SHALL have ports req_rs, req_rt, req_rd and req_shamt, each an input, 5 bits: register and shift fields.
REQ-009 The block SHALL have port req_func, input, 6 bits: funct field, used only by OP_RTYPE.
REQ-010 The block SHALL have port req_imm, input, 26 bits: imm16 in [15:0], or the jump target in [25:0].
REQ-011 The block SHALL have port load_addr, input, 1 bit: load start_addr into the write pointer.
REQ-012 The block SHALL have port start_addr, input, ADDR_W bits: the new write-pointer value.
REQ-013 The block SHALL have port clear_err, input, 1 bit: leave the ERROR state.
REQ-014 The block SHALL have port wr_en, output, 1 bit: instruction-memory write strobe.
REQ-015 The block SHALL have port wr_addr, output, ADDR_W bits: instruction-memory byte address.
REQ-016 The block SHALL have port wr_data, output, 32 bits: the encoded instruction word.
REQ-017 The block SHALL have port err, output, 1 bit: sticky illegal-request flag.

Function
REQ-018 The FSM SHALL have states IDLE, WRITE and ERROR; req_ready SHALL be 1 only in IDLE.
REQ-019 The handshake SHALL fire on req_valid&&req_ready; the request fields SHALL be sampled on that edge.
REQ-020 On a legal request the FSM SHALL go IDLE->WRITE, and wr_data SHALL be registered on the same edge.
REQ-021 In WRITE, wr_en SHALL be 1 for exactly one cycle at the current pointer; the FSM SHALL then return to IDLE and the pointer SHALL advance by 4.
REQ-022 The latency SHALL be one cycle (handshake edge N gives wr_en high in cycle N+1), for a sustained throughput of 1 word every 2 cycles.
REQ-023 The pointer SHALL wrap modulo 2^ADDR_W, so 0xFFFC+4 gives 0x0000 at ADDR_W=16.
REQ-024 The encoding SHALL be bit-exact to the CPU decoder: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0], imm[15:0], target[25:0].
REQ-025 The R-type ops OP_RTYPE, SLL, SRL, SRA and JR SHALL use opcode 000000; the shifts SHALL set funct 000000/000010/000011; JR SHALL set funct 001000 with rt=rd=shamt=0.
REQ-026 The I-type ops SHALL use these opcodes: ADDI 001000, ADDIU 001001, ANDI 001100, ORI 001101, XORI 001110, SLTI 001010, LUI 001111 (rs=0), LW 100011, SW 101011, LB 100000, SB 101000, BEQ 000100, BNE 000101, BLEZ 000110, BGTZ 000111.
REQ-027 BGEZ SHALL use opcode 000001 with rt forced to 00001.
REQ-028 J SHALL use opcode 000010 and JAL opcode 000011, each with target = req_imm[25:0].
REQ-029 An undefined req_op value SHALL be accepted, SHALL produce no write, SHALL move the FSM to ERROR and SHALL set err=1.
REQ-030 In ERROR, req_ready SHALL be 0; clear_err SHALL move the FSM to IDLE and clear err on the next edge.
REQ-031 load_addr SHALL be honoured only in IDLE and SHALL take priority over a simultaneous handshake, which SHALL stall for that cycle.
REQ-032 In WRITE and ERROR, load_addr SHALL be ignored.

Reset
REQ-033 Reset SHALL set state=IDLE, wr_en=0, wr_data=0, wr_addr=RESET_ADDR and err=0.
REQ-034 An in-flight WRITE interrupted by reset SHALL be discarded, and no wr_en pulse SHALL appear after reset.

Configuration
REQ-035 When macro INSTR_ENCODER_IMM_CHECK_EN is defined, a 16-bit-immediate op with req_imm[25:16]!=0 SHALL be treated as illegal per REQ-029.
REQ-036 When INSTR_ENCODER_IMM_CHECK_EN is undefined, req_imm[25:16] SHALL be silently dropped for those ops.

Structure
REQ-037 Package mips_pkg SHALL hold the op_t enum, all opcode and funct constants, and the field bit positions, shared with the CPU decoder.
REQ-038 Sub-module instr_encode_comb SHALL map the op and fields to {word, illegal} combinationally; the FSM, pointer and registers SHALL stay in instr_encoder.

Verification
REQ-039 ADDI with rs=1, rt=2, imm=0x0005 at pointer 0 SHALL give one cycle later wr_en=1, wr_addr=0x0000, wr_data=0x20220005.
REQ-040 Back-to-back SLL (rd=3, rt=2, shamt=4) then J (target 0x100) SHALL write 0x00021900 at 0x0000 and 0x08000100 at 0x0004, with req_ready low between them.
REQ-041 BGEZ with rs=4, imm=0xFFFE SHALL write 0x0481FFFE; JR with rs=31 SHALL write 0x03E00008.
REQ-042 load_addr with start_addr=0xFFFC followed by two requests SHALL write at 0xFFFC and then at 0x0000.
REQ-043 An undefined op SHALL give err=1, no wr_en and req_ready=0, until clear_err returns the FSM to IDLE.
REQ-044 Reset asserted in WRITE SHALL give wr_en=0 immediately and wr_addr=RESET_ADDR; with INSTR_ENCODER_IMM_CHECK_EN, ADDI with imm=0x10000 SHALL set err=1.
